// File: rtl/digest_unpacker_if.sv
// Handshake bundle between f_permutation, the digest unpacker and the
// shared-secret memory writer. master = environment side, slave = unpacker.
interface digest_unpacker_if #(
   parameter int m      = 79,
   parameter int digit  = 3,
   parameter int ADDR_W = 2
);
   localparam int W = m * digit;

   logic [575:0]        in;
   logic                in_valid;
   logic                in_ready;
   logic [W-1:0]        out;
   logic                out_valid;
   logic                out_ack;
   logic [ADDR_W-1:0]   out_addr;
   logic                out_last;
   logic                done;

   modport master (
      output in, in_valid, out_ack,
      input  in_ready, out, out_valid, out_addr, out_last, done
   );

   modport slave (
      input  in, in_valid, out_ack,
      output in_ready, out, out_valid, out_addr, out_last, done
   );
endinterface

// File: rtl/digest_unpacker.sv
// Captures the top OUT_BITS of a 576-bit rate block and streams them out
// MSB-first as NUM_WORDS words of m*digit bits with address and last flag.
module digest_unpacker #(
   parameter int m         = 79,
   parameter int digit     = 3,
   parameter int OUT_BITS  = 512,
   parameter int NUM_WORDS = 3,
   parameter int ADDR_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   digest_unpacker_if.slave bus
);
   localparam int W    = m * digit;
   localparam int SR_W = NUM_WORDS * W;
   localparam int PADZ = SR_W - OUT_BITS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   if (OUT_BITS > 576 || OUT_BITS < 1) begin : g_bad_out_bits
      $error("digest_unpacker: OUT_BITS must be in 1..576");
   end
   if (NUM_WORDS != (OUT_BITS + W - 1) / W) begin : g_bad_num_words
      $error("digest_unpacker: NUM_WORDS must equal ceil(OUT_BITS/W)");
   end
   if ((1 << ADDR_W) < NUM_WORDS) begin : g_bad_addr_w
      $error("digest_unpacker: ADDR_W too narrow for NUM_WORDS");
   end

   typedef enum logic [0:0] {IDLE, EMIT} state_t;

   state_t              state_q, state_d;
   logic [SR_W-1:0]     sreg_q, sreg_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                done_q, done_d;

   logic                capture;
   logic                word_taken;

   // Capacity/pad tail of the rate block is intentionally dropped.
   if (OUT_BITS < 576) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^bus.in[575-OUT_BITS:0];
   end

   assign capture    = (state_q == IDLE) && bus.in_valid;
   assign word_taken = (state_q == EMIT) && bus.out_ack;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      if (capture) begin
         state_d = EMIT;
         sreg_d  = {bus.in[575 -: OUT_BITS], {PADZ{1'b0}}};
         addr_d  = '0;
      end else if (word_taken) begin
         if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
         end else begin
            sreg_d  = {sreg_q[SR_W-W-1:0], {W{1'b0}}};
            addr_d  = addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out       = sreg_q[SR_W-1 -: W];
   assign bus.out_addr  = addr_q;
   assign bus.out_last  = (state_q == EMIT) && (addr_q == LAST_ADDR);
   assign bus.done      = done_q;
endmodule

// File: doc/digest_unpacker.md
Name: digest_unpacker

Overview:
- Receive end of the padder/f_permutation path. Takes one 576-bit rate block from the permutation, keeps the top OUT_BITS digest bits, and emits them as a sequence of m*digit-bit memory words.
- Each word comes with a word address and last flag for the shared-secret memory writer.
- Word layout mirrors the padder: data is MSB-aligned, word 0 = most significant bits.

Parameters:
- m, 79, field extension degree (bits per digit)
- digit, 3, digits per memory word; word width W = m*digit (237)
- OUT_BITS, 512, digest bits taken from in[575:576-OUT_BITS]; must be <= 576
- NUM_WORDS, 3, words emitted = ceil(OUT_BITS/W); must equal that value
- ADDR_W, 2, out_addr width; must satisfy 2**ADDR_W >= NUM_WORDS

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  576  rate block from f_permutation, MSB = first bit
- in_valid  input  1  in is valid this cycle
- in_ready  output  1  block accepted on clk edge when in_valid & in_ready
- out  output  W  current word, MSB-aligned
- out_valid  output  1  out/out_addr/out_last valid
- out_ack  input  1  consumer takes word on clk edge when out_valid & out_ack
- out_addr  output  ADDR_W  index of current word, 0..NUM_WORDS-1
- out_last  output  1  current word is word NUM_WORDS-1
- done  output  1  one-cycle pulse after final word accepted

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst asynchronous, active-high, and dominant over every other input.
  - While rst is high: state=IDLE, shift register=0, out_addr=0, done=0, out_valid=0, out=0, out_last=0, in_ready=1.
- States:
  - IDLE (in_ready=1, out_valid=0).
  - EMIT (in_ready=0, out_valid=1).
- IDLE -> EMIT:
  - Trigger: in_valid & in_ready at a clk edge.
  - Actions on that edge: capture in[575:576-OUT_BITS] into the MSB end of a NUM_WORDS*W-bit shift register and zero-fill the LSBs; set out_addr=0.
  - out_valid rises the cycle after capture (one-cycle latency).
- out is the top W bits of the shift register.
- Word k = digest bits [OUT_BITS-1-k*W downto ...].
  - Final word holds OUT_BITS-(NUM_WORDS-1)*W valid bits in its MSBs (38 at defaults); its LSBs are 0.
- in[575-OUT_BITS:0] (capacity/pad tail) is discarded; it never reaches out.
- EMIT, on out_ack with out_addr < NUM_WORDS-1: shift register left by W, out_addr+1, stay in EMIT.
- EMIT, on out_ack with out_addr == NUM_WORDS-1: go to IDLE, out_addr=0, done=1 for exactly the next cycle.
- EMIT, out_ack low: out, out_addr and out_last hold indefinitely. There is no timeout.
- out_last = out_valid & (out_addr == NUM_WORDS-1). This is combinational from state.
- in_valid in EMIT is ignored; the block is not captured or queued.
  - Upstream must hold in_valid until in_ready.
  - The earliest a new block can be accepted is the cycle done is high, since the state is already IDLE then.
- done and in_valid in the same cycle: the new capture proceeds normally and done still pulses once.
- Throughput: NUM_WORDS+1 cycles per block minimum (1 capture + NUM_WORDS acks).
- Reset mid-EMIT: outputs drop immediately (asynchronous), partial words are lost, no done pulse.
- out_addr never wraps past NUM_WORDS-1.

Test Plan:
- Reset: rst=1 at t=0, release after 3 cycles -> out_valid=0, in_ready=1, done=0, out_addr=0 throughout.
- Full block, out_ack tied 1: in[575:64]=all ones, in[63:0]=0, in_valid for 1 cycle.
  - Next cycle: out_valid=1, addr 0.
  - Then three consecutive words: addr 0/1/2 = 237'h1..1, 237'h1..1, {38 ones, 199 zeros}.
  - out_last only on addr 2; done=1 the cycle after the third ack, else 0.
- Ordering: in = {512-bit counter pattern 0x0001_0203...3F, 64'h0}.
  - Concatenated out words (first 512 bits) must equal the digest exactly, MSB first.
- Backpressure: during addr 1, drop out_ack for 5 cycles -> out and out_addr=1 stable, out_valid=1, done=0; resume -> addr 2 follows.
- Overlap: pulse in_valid with a second block at addr 1 -> ignored, in_ready=0; holding in_valid through done -> second block is captured on the done cycle and word 0 of block 2 appears the next cycle.
- Capacity discard: in[575:64]=0, in[63:0]=all ones -> all three words 0. Async rst mid-EMIT (between edges) -> out_valid=0 before the next edge, out_addr=0.
